uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Queues outbound UART bytes from two requesters, the core's MMIO write path and the debug/trap-message unit, in one shared FIFO. It drains that FIFO into the UART transmitter one byte at a time, sequencing the single-cycle start strobe against the transmitter's busy flag. It sits between the MMIO address decode and the UART TX core, so software writes do not stall or drop when the transmitter is busy.

## Interface
Parameters:
- FIFO_DEPTH, 16, queue entries; power of two, minimum 2.
- BUSY_TIMEOUT, 4, cycles to wait for UART_busy to rise after a start strobe before the byte is treated as sent; minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- core_wr_valid  input  1  core byte write request.
- core_wr_data  input  8  core byte.
- core_wr_ready  output  1  core byte accepted this cycle (combinational).
- dbg_wr_valid  input  1  debug byte write request.
- dbg_wr_data  input  8  debug byte.
- dbg_wr_ready  output  1  debug byte accepted this cycle (combinational).
- UART_busy  input  1  transmitter frame in progress.
- uart_tx_data  output  8  byte presented to the transmitter; registered.
- uart_tx_start  output  1  one-cycle start strobe; registered.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- fifo_empty  output  1  fifo_count == 0.
- fifo_full  output  1  fifo_count == FIFO_DEPTH.

## Operation
- Enqueue: at most one byte per cycle. A transfer happens when valid && ready at the rising edge.
- Ready: both readies are 0 when fifo_full is high, based on the registered count. There is no same-cycle pop bypass.
- Arbitration when both requesters are valid and the FIFO is not full: exactly one ready is high, chosen by the policy in Configuration. A lone valid requester always gets ready when the FIFO is not full.
- FIFO: circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop: count is unchanged and the data order is preserved.
- Drain FSM states:
  - IDLE: if !fifo_empty && !UART_busy, pop the head into uart_tx_data, set uart_tx_start = 1, clear the timer, and go to WAIT_BUSY.
  - WAIT_BUSY: uart_tx_start = 0. If UART_busy, go to WAIT_DONE. Otherwise the timer increments; when it reaches BUSY_TIMEOUT, go to IDLE.
  - WAIT_DONE: go to IDLE when !UART_busy.
- uart_tx_data holds its value until the next pop.

## Timing
- Reset values: uart_tx_data = 0x00, uart_tx_start = 0, fifo_count = 0, fifo_empty = 1, fifo_full = 0, state = IDLE, round-robin pointer = core.
- Latency: for a byte accepted at edge E0 into an empty FIFO while the UART is idle, uart_tx_start is high for exactly the cycle after E1; fifo_count is back to 0 after E1.
- uart_tx_start is never high for two consecutive cycles. A new start is never issued while the FSM is outside IDLE.
- Minimum spacing between start strobes is UART_busy high time + 2 cycles, or BUSY_TIMEOUT + 2 cycles when busy never rises.
- Reset mid-operation: queued bytes are discarded, uart_tx_start drops on the reset edge, and the FSM returns to IDLE. A frame already in the transmitter is not aborted.
- UART_busy high while the FSM is in IDLE: no pop occurs; the FSM waits.

## Configuration
- UART_TXQ_ROUND_ROBIN_EN
  - Defined: round-robin arbitration. On each contested grant the pointer toggles to the other requester. Uncontested grants leave the pointer unchanged.
  - Undefined: fixed priority, debug over core. The pointer logic is absent.

## Test plan
- Single byte: reset, core writes 0x41 with UART idle -> core_wr_ready = 1; uart_tx_start pulses once, 2 cycles after acceptance, with uart_tx_data = 0x41; fifo_count returns to 0.
- Fill: hold UART_busy = 1 and write 17 bytes 0x00..0x10 with FIFO_DEPTH = 16 -> fifo_full after 16 accepts; the 17th stalls with ready = 0; after busy releases, bytes emerge as 0x00..0x0F in order, then 0x10.
- Contention: both requesters valid continuously, core 0xC0.., debug 0xD0.. -> with the macro, grants alternate starting with core; without it, all debug bytes are granted first.
- Busy timeout: UART_busy tied 0, push 0x55 -> start pulse, then return to IDLE exactly BUSY_TIMEOUT+1 cycles later; the next queued byte starts on the following cycle.
- Reset mid-drain: 5 bytes queued, first frame in flight, reset_n = 0 for 1 cycle -> fifo_count = 0, uart_tx_start = 0, no further strobes.
- Wrap: push and pop 40 bytes with FIFO_DEPTH = 16, random UART_busy lengths -> output sequence equals input sequence; count never exceeds 16.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Merges outbound bytes from the core MMIO write path and the debug/trap
// message unit into one circular FIFO. A small drain FSM then pops the FIFO
// one byte at a time into the UART transmitter. It issues a single-cycle
// start strobe and waits for the transmitter's busy flag to rise and fall.
// If busy never rises within BUSY_TIMEOUT cycles, the byte is treated as sent.
//
// Parameters:
//   FIFO_DEPTH    queue entries (power of two, >= 2)
//   BUSY_TIMEOUT  cycles to wait for UART_busy after a start strobe (>= 1)
//
// Ports:
//   clk, reset_n               clock; synchronous active-low reset
//   core_wr_valid/data/ready   core byte write handshake (ready is combinational)
//   dbg_wr_valid/data/ready    debug byte write handshake (ready is combinational)
//   UART_busy                  transmitter frame in progress
//   uart_tx_data               registered byte presented to the transmitter
//   uart_tx_start              registered one-cycle start strobe
//   fifo_count/empty/full      FIFO occupancy status
//
// Build option:
//   UART_TXQ_ROUND_ROBIN_EN    when defined, contested writes alternate between
//                              the two requesters, starting with core.
//                              When undefined, debug has fixed priority over core.

module uart_tx_scheduler #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          core_wr_valid,
  input  logic [7:0]                    core_wr_data,
  output logic                          core_wr_ready,
  input  logic                          dbg_wr_valid,
  input  logic [7:0]                    dbg_wr_data,
  output logic                          dbg_wr_ready,
  input  logic                          UART_busy,
  output logic [7:0]                    uart_tx_data,
  output logic                          uart_tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty,
  output logic                          fifo_full
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic          empty_int;
  logic          full_int;

  // Drain FSM
  state_t        state_reg;
  state_t        state_next;
  logic [TW-1:0] timer_reg;

  logic          pop;
  logic          timer_clear;
  logic          timer_inc;

  // Output registers
  logic [7:0]    tx_data_reg;
  logic          tx_start_reg;

  // Write side
  logic          core_fire;
  logic          dbg_fire;
  logic          push;
  logic [7:0]    wr_data;

  assign empty_int = (count_reg == '0);
  assign full_int  = (count_reg == DEPTH_C);

  // ---------------------------------------------------------------------------
  // Write arbitration. Readies depend only on the registered count. A pop in
  // the same cycle does not open a slot early.
  // ---------------------------------------------------------------------------
`ifdef UART_TXQ_ROUND_ROBIN_EN
  // 0: core wins the next contested cycle, 1: debug wins it.
  logic rr_dbg_reg;
  logic contested;

  assign contested     = core_wr_valid && dbg_wr_valid && !full_int;
  assign core_wr_ready = !full_int && (!dbg_wr_valid || !rr_dbg_reg);
  assign dbg_wr_ready  = !full_int && (!core_wr_valid || rr_dbg_reg);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_dbg_reg <= 1'b0;
    end else if (contested) begin
      rr_dbg_reg <= !rr_dbg_reg;
    end
  end
`else
  assign dbg_wr_ready  = !full_int;
  assign core_wr_ready = !full_int && !dbg_wr_valid;
`endif

  assign core_fire = core_wr_valid && core_wr_ready;
  assign dbg_fire  = dbg_wr_valid && dbg_wr_ready;
  assign push      = core_fire || dbg_fire;
  assign wr_data   = dbg_fire ? dbg_wr_data : core_wr_data;

  // ---------------------------------------------------------------------------
  // FIFO storage: plain array, no reset, so it maps onto RAM. The read port is
  // registered through tx_data_reg, which also holds the byte between pops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_data_reg <= 8'h00;
    end else if (pop) begin
      tx_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Drain FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (!empty_int && !UART_busy) begin
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (UART_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TIMEOUT_C) begin
          // Busy never rose. Give up on seeing it and treat the byte as sent.
          state_next = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!UART_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Drain FSM: output logic
  always_comb begin
    pop         = 1'b0;
    timer_clear = 1'b0;
    timer_inc   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_int && !UART_busy) begin
          pop         = 1'b1;
          timer_clear = 1'b1;
        end
      end
      WAIT_BUSY: begin
        if (!UART_busy && (timer_reg != TIMEOUT_C)) begin
          timer_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_reg <= '0;
    end else if (timer_clear) begin
      timer_reg <= '0;
    end else if (timer_inc) begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  // The strobe is the registered pop. A pop only happens in IDLE, and the FSM
  // leaves IDLE on the same edge, so two strobes can never be adjacent.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_start_reg <= 1'b0;
    end else begin
      tx_start_reg <= pop;
    end
  end

  assign uart_tx_data  = tx_data_reg;
  assign uart_tx_start = tx_start_reg;
  assign fifo_count    = count_reg;
  assign fifo_empty    = empty_int;
  assign fifo_full     = full_int;

endmodule
